acc_cpu_core: RTL and testbench
===============================

Name: acc_cpu_core

Overview:
- Parametrised successor of the 8-bit accumulator CPU: DATA_W-bit accumulator, ADDR_W-bit program/data address space, 3-bit opcode ISA.
- Program is loaded over a valid/ready stream (fed by the UART receiver or a test host). Execution then runs through an explicit FETCH/EXEC state machine.
- New over the previous generation: handshaked loader, single-step mode, carry flag, halted status, clean restart without reset.

Parameters:
- DATA_W, 8, accumulator/data-memory word width (>=2)
- ADDR_W, 5, program counter / memory address width; both memories have 2**ADDR_W entries
- INS_W, 3+ADDR_W, instruction width (derived; do not override)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Load  in  1  level; high = loader mode, CPU stopped
- prog_valid  in  1  loader word valid
- prog_data  in  INS_W  instruction word {opcode[2:0], addr[ADDR_W-1:0]}
- prog_ready  out  1  loader ready (high only in LOAD state)
- Step_mode  in  1  1 = execute one instruction per Step pulse
- Step  in  1  single-cycle pulse to release one instruction in step mode
- Instruction  out  INS_W  current instruction register
- Acc  out  DATA_W  accumulator
- Mem  out  DATA_W  data-memory word at IR address (combinational read)
- Program_counter  out  ADDR_W  PC
- Carry  out  1  carry out of last ADD
- Zero  out  1  Acc == 0 (combinational)
- Halted  out  1  high in HALT state

Behaviour:
- Reset (async): state=IDLE; PC=0, IR=0, Acc=0, Carry=0, load pointer=0, all data memory cleared. Instruction memory is not cleared. Outputs: prog_ready=0, Halted=0, Zero=1.
- ISA:
  - HLT 000: halt.
  - SKZ 001: if Acc==0 then PC+=2, else PC+=1.
  - ADD 010: {Carry,Acc} <= Acc+M.
  - AND 011: Acc <= Acc&M.
  - XOR 100: Acc <= Acc^M.
  - LDA 101: Acc <= M.
  - STO 110: M <= Acc.
  - JMP 111: PC <= addr.
  - M = dmem[IR.addr]. All PC arithmetic is modulo 2**ADDR_W.
- States: IDLE, LOAD, FETCH, EXEC, WAIT, HALT.
- Load=1 from any state: next state LOAD.
  - ptr=0 on LOAD entry; Acc, dmem, PC unchanged.
  - In LOAD: prog_ready=1. On prog_valid&prog_ready, imem[ptr] <= prog_data and ptr++ (wraps to 0 after 2**ADDR_W-1; later words overwrite).
- Load falling (LOAD, Load=0): PC=0, next FETCH.
- IDLE with Load=0 goes to FETCH, so a post-reset run executes the stored program.
- FETCH (1 cycle): IR <= imem[PC]; next EXEC.
- EXEC (1 cycle):
  - Execute IR and update PC (PC+1 unless SKZ/JMP).
  - Acc/Carry/dmem write on the rising edge ending EXEC.
  - Carry changes only on ADD.
  - Next state: HLT goes to HALT with PC not advanced. Otherwise WAIT if Step_mode=1, else FETCH.
- Throughput: exactly 2 cycles per instruction in run mode.
- WAIT: hold all state. Step=1 goes to FETCH. Step_mode dropping to 0 also goes to FETCH. Step outside WAIT is ignored.
- HALT: Halted=1; all state held. Exit only via Load=1 or Reset.
- Mem mirrors dmem[IR.addr] continuously, including the value just written after STO.
- Reset mid-operation: immediate return to IDLE. Partial load is preserved in imem.
- Load asserted mid-EXEC: that instruction's writes are suppressed; Load has priority.

Test Plan:
- Load words 0xA3 (LDA 3), 0x44 (ADD 4), 0xC5 (STO 5), 0x00 (HLT) with dmem[3]=0 default, then drop Load -> after 8 cycles Halted=1, Acc=0, Mem=0, PC=3; prog_ready high only while Load=1.
- DATA_W=8: preset dmem[3]=0xF0, dmem[4]=0x20 by program (LDA/XOR/STO), then ADD -> Acc=0x10, Carry=1; next ADD of 0x01 -> Carry=0.
- SKZ with Acc=0 at PC=6 -> next fetched PC=8. With Acc=0x01 -> PC=7. SKZ at PC=31 (ADDR_W=5) wraps to PC=1.
- JMP 0x1F then JMP 0x02 loop -> PC alternates 31, 2, never halts. Assert Load -> prog_ready=1 within 1 cycle; no dmem write.
- Step_mode=1, program of 3 instructions -> each Step pulse advances exactly one instruction (PC 0->1->2); no progress without Step.
- Reset pulse during EXEC of STO -> dmem not written, Acc=0, PC=0, Halted=0. Rerun without reload executes original program.

Source files
------------

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: handshaked program loader, FETCH/EXEC sequencer,
// optional single-step mode and a carry flag on ADD.
module acc_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INS_W  = 3 + ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic              prog_valid,
  input  logic [INS_W-1:0]  prog_data,
  output logic              prog_ready,
  input  logic              Step_mode,
  input  logic              Step,
  output logic [INS_W-1:0]  Instruction,
  output logic [DATA_W-1:0] Acc,
  output logic [DATA_W-1:0] Mem,
  output logic [ADDR_W-1:0] Program_counter,
  output logic              Carry,
  output logic              Zero,
  output logic              Halted
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StLoad, StFetch, StExec, StWait, StHalt
  } state_e;

  typedef enum logic [2:0] {
    OpHlt = 3'd0, OpSkz = 3'd1, OpAdd = 3'd2, OpAnd = 3'd3,
    OpXor = 3'd4, OpLda = 3'd5, OpSto = 3'd6, OpJmp = 3'd7
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              imem_we, dmem_we;

  logic [INS_W-1:0]  imem   [Depth];
  logic [DATA_W-1:0] dmem_q [Depth];

  op_e               op;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] m_word;

  assign op      = op_e'(ir_q[INS_W-1 -: 3]);
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign m_word  = dmem_q[ir_addr];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    imem_we = 1'b0;
    dmem_we = 1'b0;

    if (state_q == StLoad && prog_valid) begin
      imem_we = 1'b1;
      ptr_d   = ptr_q + ADDR_W'(1);
    end

    // Load overrides everything, including the writes of an in-flight EXEC.
    if (Load) begin
      state_d = StLoad;
      if (state_q != StLoad) begin
        ptr_d   = '0;
        imem_we = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StFetch;
        StLoad: begin
          pc_d    = '0;
          state_d = StFetch;
        end
        StFetch: begin
          ir_d    = imem[pc_q];
          state_d = StExec;
        end
        StExec: begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = Step_mode ? StWait : StFetch;
          unique case (op)
            OpHlt: begin
              pc_d    = pc_q;
              state_d = StHalt;
            end
            OpSkz: if (acc_q == '0) pc_d = pc_q + ADDR_W'(2);
            OpAdd: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, m_word};
            OpAnd: acc_d = acc_q & m_word;
            OpXor: acc_d = acc_q ^ m_word;
            OpLda: acc_d = m_word;
            OpSto: dmem_we = 1'b1;
            OpJmp: pc_d = ir_addr;
          endcase
        end
        StWait: if (Step || !Step_mode) state_d = StFetch;
        StHalt: state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ptr_q   <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < Depth; i++) dmem_q[i] <= '0;
    end else if (dmem_we) begin
      dmem_q[ir_addr] <= acc_q;
    end
  end

  // Program memory survives reset so a stored program can be rerun.
  always_ff @(posedge Clk) begin
    if (imem_we) imem[ptr_q] <= prog_data;
  end

  assign prog_ready      = (state_q == StLoad);
  assign Halted          = (state_q == StHalt);
  assign Instruction     = ir_q;
  assign Acc             = acc_q;
  assign Mem             = m_word;
  assign Program_counter = pc_q;
  assign Carry           = carry_q;
  assign Zero            = (acc_q == '0);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core against an instruction-level model.
module tb_acc_cpu_core;

  localparam int DEPTH = 32;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Load;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       Step_mode;
  logic       Step;
  logic [7:0] Instruction;
  logic [7:0] Acc;
  logic [7:0] Mem;
  logic [4:0] Program_counter;
  logic       Carry;
  logic       Zero;
  logic       Halted;

  acc_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_ready(prog_ready), .Step_mode(Step_mode),
    .Step(Step), .Instruction(Instruction), .Acc(Acc), .Mem(Mem),
    .Program_counter(Program_counter), .Carry(Carry), .Zero(Zero), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Architectural model: one call = one instruction.
  logic [7:0] m_imem [DEPTH];
  int         m_dmem [DEPTH];
  int         m_acc, m_carry, m_pc, m_ir, m_halt;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_dmem[i] = 0;
    m_acc = 0; m_carry = 0; m_pc = 0; m_ir = 0; m_halt = 0;
  endtask

  task automatic model_step();
    int op, a, sum, npc;
    m_ir = int'(m_imem[m_pc]);
    op   = m_ir / 32;
    a    = m_ir % 32;
    npc  = (m_pc + 1) % DEPTH;
    case (op)
      0: begin m_halt = 1; npc = m_pc; end
      1: if (m_acc == 0) npc = (m_pc + 2) % DEPTH;
      2: begin sum = m_acc + m_dmem[a]; m_carry = (sum > 255) ? 1 : 0; m_acc = sum % 256; end
      3: m_acc = m_acc & m_dmem[a];
      4: m_acc = m_acc ^ m_dmem[a];
      5: m_acc = m_dmem[a];
      6: m_dmem[a] = m_acc;
      default: npc = a;
    endcase
    m_pc = npc;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Push the whole model image through the loader, Load left high afterwards.
  task automatic load_image();
    Load = 1'b1;
    tick();
    n_cmp++;
    if (prog_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_ready: got %b want 1", prog_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        prog_valid = 1'b0;
        tick();
      end
      prog_valid = 1'b1;
      prog_data  = m_imem[i];
      tick();
    end
    prog_valid = 1'b0;
  endtask

  task automatic start_run();
    Load = 1'b0;
    m_pc = 0; m_halt = 0;
    tick();
    n_cmp++;
    if (prog_ready !== 1'b0 || Program_counter !== 5'd0) begin
      n_fail++;
      $display("FAIL start_run: ready=%b pc=%0d want ready=0 pc=0", prog_ready, Program_counter);
    end
  endtask

  task automatic check_state(input string tag);
    n_cmp++;
    if (Program_counter !== 5'(m_pc) || Acc !== 8'(m_acc) || Carry !== 1'(m_carry) ||
        Halted !== 1'(m_halt) || Instruction !== 8'(m_ir) || Zero !== (m_acc == 0) ||
        Mem !== 8'(m_dmem[m_ir % 32])) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d acc=%h c=%b h=%b ir=%h z=%b mem=%h want pc=%0d acc=%h c=%0d h=%0d ir=%h mem=%h",
               tag, Program_counter, Acc, Carry, Halted, Instruction, Zero, Mem,
               m_pc, m_acc, m_carry, m_halt, m_ir, m_dmem[m_ir % 32]);
    end
  endtask

  // Two cycles per instruction in run mode.
  task automatic exec_instr(input string tag);
    tick();
    tick();
    model_step();
    check_state(tag);
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n && m_halt == 0; i++) exec_instr(tag);
  endtask

  task automatic fill_image(input logic [7:0] fill);
    for (int i = 0; i < DEPTH; i++) m_imem[i] = fill;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Load = 1'b1; prog_valid = 1'b0; prog_data = '0;
    Step_mode = 1'b0; Step = 1'b0;
    tick(); tick();
    model_reset();
    n_cmp++;
    if (prog_ready !== 1'b0 || Halted !== 1'b0 || Zero !== 1'b1 || Acc !== 8'h00 ||
        Program_counter !== 5'd0 || Instruction !== 8'h00 || Carry !== 1'b0 || Mem !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: ready=%b halt=%b z=%b acc=%h pc=%0d ir=%h c=%b mem=%h",
               prog_ready, Halted, Zero, Acc, Program_counter, Instruction, Carry, Mem);
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    fill_image(8'h00);
    m_imem[0] = 8'hA3; m_imem[1] = 8'h44; m_imem[2] = 8'hC5; m_imem[3] = 8'h00;
    load_image();
    start_run();
    run_n(10, "basic");
    n_cmp++;
    if (Halted !== 1'b1 || Program_counter !== 5'd3 || Acc !== 8'h00 || prog_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: halt=%b pc=%0d acc=%h ready=%b want 1 3 00 0",
               Halted, Program_counter, Acc, prog_ready);
    end
    tick(); tick();
    check_state("halt_hold");
  endtask

  task automatic test_skz();
    fill_image(8'h00);
    m_imem[0] = 8'hE6; m_imem[6] = 8'h20; m_imem[8] = 8'hFF; m_imem[31] = 8'h20;
    load_image();
    start_run();
    run_n(8, "skz");
    n_cmp++;
    if (Halted !== 1'b1 || Program_counter !== 5'd1) begin
      n_fail++;
      $display("FAIL skz_wrap: halt=%b pc=%0d want 1 1", Halted, Program_counter);
    end
  endtask

  task automatic test_jmp_loop();
    fill_image(8'h00);
    m_imem[0] = 8'hFF; m_imem[31] = 8'hE2; m_imem[2] = 8'hFF;
    load_image();
    start_run();
    run_n(9, "jmp_loop");
    tick();  // EXEC of the next JMP; Load must suppress its PC update
    Load = 1'b1;
    tick();
    n_cmp++;
    if (prog_ready !== 1'b1 || Program_counter !== 5'(m_pc) || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL load_mid_exec: ready=%b pc=%0d halt=%b want 1 %0d 0",
               prog_ready, Program_counter, Halted, m_pc);
    end
  endtask

  task automatic test_step();
    fill_image(8'h00);
    m_imem[0] = 8'hA1; m_imem[1] = 8'h42; m_imem[2] = 8'h00;
    load_image();
    Step_mode = 1'b1;
    start_run();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        Step = 1'b1;
        tick();
        Step = 1'b0;
      end
      exec_instr("step");
      for (int w = 0; w < 4; w++) tick();
      check_state("step_hold");
    end
    Step_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_image(8'h00);
    m_imem[0] = 8'hA3; m_imem[1] = 8'hC5; m_imem[2] = 8'h00;
    load_image();
    start_run();
    exec_instr("pre_reset");
    tick();  // now in EXEC of STO
    n_cmp++;
    if (Instruction !== 8'hC5) begin
      n_fail++; $display("FAIL sto_fetch: got %h want c5", Instruction);
    end
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
    check_state("reset_mid");
    start_run();
    run_n(6, "rerun");
    n_cmp++;
    if (Halted !== 1'b1 || Program_counter !== 5'd2) begin
      n_fail++; $display("FAIL rerun_end: halt=%b pc=%0d want 1 2", Halted, Program_counter);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < DEPTH; i++) m_imem[i] = 8'($urandom);
      load_image();
      start_run();
      run_n(20, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skz();
    test_jmp_loop();
    test_step();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
